// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state type and operand-signedness predicates.
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIN  = 2'd2
  } md_state_e;

  function automatic logic is_div(input logic [2:0] funct3);
    return funct3[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] funct3);
    return funct3[2] & funct3[1];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] funct3);
    return (funct3 == MD_MUL) || (funct3 == MD_MULH) || (funct3 == MD_MULHSU) ||
           (funct3 == MD_DIV) || (funct3 == MD_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] funct3);
    return (funct3 == MD_MUL) || (funct3 == MD_MULH) ||
           (funct3 == MD_DIV) || (funct3 == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide unit for RV32M: shift-add multiply and
// restoring divide on magnitudes, sign fix-up in a final cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state;
  logic [2:0]        op;
  logic              neg_a;
  logic              neg_b;
  logic              special;
  logic [2*XLEN-1:0] acc;
  logic [XLEN:0]     rem;
  logic [XLEN-1:0]   opb;
  logic [CW-1:0]     count;

  logic              a_neg_in;
  logic              b_neg_in;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   special_val;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rmd;
  logic [XLEN-1:0]   fin_val;

  // NOTE: every variable gets a default at the top so no path can infer a latch.
  always_comb begin
    a_neg_in    = is_signed_a(funct3) && a[XLEN-1];
    b_neg_in    = is_signed_b(funct3) && b[XLEN-1];
    a_mag       = a_neg_in ? -a : a;
    b_mag       = b_neg_in ? -b : b;
    div_zero    = is_div(funct3) && (b == '0);
    div_ovf     = ((funct3 == MD_DIV) || (funct3 == MD_REM)) && (a == MIN_INT) && (b == '1);
    special_val = '0;
    if (div_zero)     special_val = is_rem(funct3) ? a : '1;
    else if (div_ovf) special_val = is_rem(funct3) ? '0 : MIN_INT;

    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    div_shift = {rem[XLEN-1:0], acc[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opb};

    // The remainder always fits in XLEN bits once a step has completed.
    prod = (neg_a != neg_b) ? -acc : acc;
    quo  = (neg_a != neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rmd  = neg_a ? XLEN'(-rem) : XLEN'(rem);

    fin_val = rmd;
    if (special) fin_val = acc[XLEN-1:0];
    else begin
      case (op)
        MD_MUL:                      fin_val = prod[XLEN-1:0];
        MD_MULH, MD_MULHSU, MD_MULHU: fin_val = prod[2*XLEN-1:XLEN];
        MD_DIV, MD_DIVU:             fin_val = quo;
        default:                     fin_val = rmd;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments only; datapath registers are reset
  // too so a fresh unit never exposes X through the sign fix-up logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= MD_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      count   <= '0;
      op      <= MD_MUL;
      neg_a   <= 1'b0;
      neg_b   <= 1'b0;
      special <= 1'b0;
      acc     <= '0;
      rem     <= '0;
      opb     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (start) begin
            op      <= funct3;
            neg_a   <= a_neg_in;
            neg_b   <= b_neg_in;
            opb     <= b_mag;
            rem     <= '0;
            busy    <= 1'b1;
            special <= div_zero || div_ovf;
            if (div_zero || div_ovf) begin
              acc   <= {{XLEN{1'b0}}, special_val};
              count <= '0;
              state <= MD_FIN;
            end else begin
              acc   <= {{XLEN{1'b0}}, a_mag};
              count <= CW'(XLEN);
              state <= MD_CALC;
            end
          end
        end
        MD_CALC: begin
          if (is_div(op)) begin
            acc[XLEN-1:0] <= {acc[XLEN-2:0], div_ge};
            rem           <= div_ge ? (div_shift - {1'b0, opb}) : div_shift;
          end else begin
            acc <= {mul_sum, acc[XLEN-1:1]};
          end
          count <= count - CW'(1);
          if (count == CW'(1)) state <= MD_FIN;
        end
        MD_FIN: begin
          result <= fin_val;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= MD_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= MD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, handshake and
// reset behaviour, then random operations against a 64-bit arithmetic model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN = 32;
  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint          sa, sb, ua, ub, p;
    longint unsigned up;
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    ua = {32'b0, x};
    ub = {32'b0, y};
    p  = 0;
    up = 0;
    case (f)
      MD_MUL:    begin p = sa * sb; return p[31:0]; end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * ub; return p[63:32]; end
      MD_MULHU:  begin up = ua * ub; return up[63:32]; end
      MD_DIV: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == MIN_INT && y == 32'hFFFF_FFFF) return MIN_INT;
        p = sa / sb; return p[31:0];
      end
      MD_DIVU: begin
        if (y == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      MD_REM: begin
        if (y == 0) return x;
        if (x == MIN_INT && y == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (y == 0) return x;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_special_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    return f[2] && ((y == 0) || (!f[0] && x == MIN_INT && y == 32'hFFFF_FFFF));
  endfunction

  // Issue one op from a negedge, follow it to done, check latency, busy, held result and value.
  task automatic do_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input string tag, input int poke_at);
    logic [31:0] prev;
    int          k;
    int          lat;
    bit          busy_ok;
    bit          held_ok;
    prev    = result;
    lat     = is_special_op(f, x, y) ? 1 : 33;
    busy_ok = 1'b1;
    held_ok = 1'b1;
    funct3  = f;
    a       = x;
    b       = y;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    a      = $urandom;
    b      = $urandom;
    funct3 = 3'($urandom_range(0, 7));
    for (k = 0; k < 46; k++) begin
      @(negedge clk);
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      if (result !== prev) held_ok = 1'b0;
      if (k == poke_at) begin
        start  = 1'b1;
        funct3 = MD_DIVU;
        a      = 32'h1234_5678;
        b      = 32'h0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "/latency"}, 64'(k), 64'(lat));
    check({tag, "/busy_during"}, 64'(busy_ok), 64'd1);
    check({tag, "/result_held"}, 64'(held_ok), 64'd1);
    check({tag, "/busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "/result"}, 64'(result), 64'(exp));
  endtask

  initial begin
    int t_done;
    int n_done;
    logic [2:0]  rf;
    logic [31:0] ra;
    logic [31:0] rb;
    int          sel;

    reset  = 1'b1;
    start  = 1'b0;
    funct3 = 3'b000;
    a      = '0;
    b      = '0;
    repeat (3) @(negedge clk);
    check("reset/busy", 64'(busy), 64'd0);
    check("reset/done", 64'(done), 64'd0);
    check("reset/result", 64'(result), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op(MD_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3", -1);
    @(negedge clk);
    check("done_pulse_width", 64'(done), 64'd0);
    check("result_after_done", 64'(result), 64'hFFFF_FFEB);

    do_op(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_ones", -1);
    do_op(MD_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_ones", -1);
    do_op(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ones", -1);
    do_op(MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_m7_2", -1);
    do_op(MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_m7_2", -1);
    do_op(MD_DIVU,   32'd100,       32'd7,         32'd14,        "divu_100_7", -1);
    do_op(MD_REMU,   32'd100,       32'd7,         32'd2,         "remu_100_7", -1);
    do_op(MD_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, "div_by_zero", -1);
    do_op(MD_REMU,   32'd5,         32'd0,         32'd5,         "remu_by_zero", -1);
    do_op(MD_DIV,    MIN_INT,       32'hFFFF_FFFF, MIN_INT,       "div_overflow", -1);
    do_op(MD_REM,    MIN_INT,       32'hFFFF_FFFF, 32'd0,         "rem_overflow", -1);

    // A start raised mid-operation must neither restart nor disturb the result.
    do_op(MD_MUL, 32'd123, 32'd456, 32'd56088, "mul_ignored_start", 10);
    t_done = cyc;
    do_op(MD_MULHU, 32'h8000_0001, 32'd6, 32'd3, "back_to_back", -1);
    check("back_to_back/spacing", 64'(cyc - t_done), 64'd34);

    // Reset during CALC aborts the operation without a done pulse.
    funct3 = MD_MUL;
    a      = 32'd9;
    b      = 32'd9;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort/busy", 64'(busy), 64'd0);
    check("abort/done", 64'(done), 64'd0);
    check("abort/result", 64'(result), 64'd0);
    reset  = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort/no_done", 64'(n_done), 64'd0);

    // Reset and start together: reset wins.
    reset  = 1'b1;
    start  = 1'b1;
    funct3 = MD_DIVU;
    a      = 32'd1;
    b      = 32'd0;
    @(negedge clk);
    check("reset_vs_start/busy", 64'(busy), 64'd0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("reset_vs_start/idle", 64'(busy), 64'd0);

    for (int i = 0; i < 40; i++) begin
      rf  = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = MIN_INT; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 15));
      else if (sel == 3) rb = -32'($urandom_range(1, 15));
      do_op(rf, ra, rb, model(rf, ra, rb), $sformatf("rand%0d_f%0d", i, rf), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
